writeback_stage: RTL
====================

# writeback_stage

The writeback stage of the pipelined Y86-64 processor holds the W pipeline register, which is fed by the memory stage. It also owns the architectural register file (15 × 64-bit) and commits valE and valM at the end of each instruction's writeback cycle. Its reg_mem0..reg_mem14 outputs feed the decode stage's register-file inputs directly. Its W_* outputs feed the decode-stage forwarding logic.

## Interface

Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.

Parameters:
- `RSP_INIT`, default 64'h0000_0000_0000_0200: reset value of reg_mem4 (%rsp).

Ports (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `M_stat` in 2: status from memory stage (AOK=0, HLT=1, ADR=2, INS=3).
- `M_icode` in 4: instruction code from memory stage.
- `M_valE` in 64: ALU result.
- `M_valM` in 64: memory read data.
- `M_dstE` in 4: destination register for valE; 4'hF means none.
- `M_dstM` in 4: destination register for valM; 4'hF means none.
- `W_stall` in 1: hold the W register.
- `W_bubble` in 1: load a NOP bubble into the W register.
- `W_stat` out 2: registered status.
- `W_icode` out 4: registered icode.
- `W_valE` out 64: registered valE, also a forwarding source.
- `W_valM` out 64: registered valM, also a forwarding source.
- `W_dstE` out 4: registered dstE.
- `W_dstM` out 4: registered dstM.
- `reg_mem0` … `reg_mem14` out 64 each: architectural registers, ordered %rax … %r14.
- `halted` out 1: sticky; the processor has retired a non-AOK instruction.

## Operation

- **W register update, at each rising edge, priority high to low:**
  1. `rst`.
  2. `halted` set: hold.
  3. `W_stall`: hold.
  4. `W_bubble`: load stat=AOK, icode=4'h1 (NOP), valE=0, valM=0, dstE=4'hF, dstM=4'hF.
  5. Otherwise: load M_*.
  - W_stall together with W_bubble: stall wins.
- **Register write, at the same edge, using the current W_* values (before update):**
  - Writes occur only if W_stat==AOK and halted==0.
  - If W_dstE≠4'hF, write reg_mem[W_dstE] ← W_valE.
  - If W_dstM≠4'hF, write reg_mem[W_dstM] ← W_valM.
  - If W_dstE==W_dstM (and both ≠F), valM wins. This covers popq %rsp.
  - Register index 4'hF is never written.
- **W_stall does not suppress the register write.** The held instruction is rewritten with identical data each cycle, which is harmless and required.
- **Halt:**
  - At an edge where W_stat≠AOK and halted==0, set halted ← 1.
  - That instruction performs no register write.
  - halted clears only on rst.
- **Reset (asynchronous):**
  - W_stat=AOK, W_icode=4'h1, W_valE=0, W_valM=0, W_dstE=4'hF, W_dstM=4'hF.
  - All reg_memN=0 except reg_mem4=RSP_INIT.
  - halted=0.
- All outputs are register outputs. There is no combinational path from input to output.

## Timing

- **M → W:** M_* sampled at edge N appears on W_* after edge N.
- **W → register file:** that instruction's write is visible on reg_memN after edge N+1. Total M-to-register latency is 2 cycles.
- **Decode must forward** from W_valE/W_valM for a reader in the cycle between edges N and N+1. reg_memN does not yet reflect the write in that window.
- **Halt timing:** halted rises after edge N+1 for a non-AOK status captured at edge N. From then on, W_* and reg_memN are frozen.
- **Reset mid-operation:** reset takes effect immediately and asynchronously. Any in-flight W contents are discarded unwritten.

## Structure

- **Shared package `y86_pkg`:**
  - stat codes (STAT_AOK/HLT/ADR/INS)
  - icode constants (I_HALT … I_POPQ, I_NOP=4'h1)
  - register constants RNONE=4'hF, RRSP=4'h4
  - bubble value constants
- **Sub-module `regfile_15x64`:**
  - two write ports with port-M priority
  - write enable
  - async reset with RSP_INIT
  - 15 parallel 64-bit read outputs
- **Top level** contains the W register, the halt logic, and the regfile_15x64 instance.

## Test plan

- **Reset:** assert rst mid-cycle → immediately W_icode=1, W_dstE=F, all reg_memN=0, reg_mem4=0x200, halted=0.
- **Single write:** M_stat=AOK, dstE=3, valE=0x1234, dstM=F, one cycle → W_valE=0x1234 after edge 1; reg_mem3=0x1234 after edge 2; all other registers unchanged.
- **Dual-write conflict:** dstE=4, valE=0x208, dstM=4, valM=0xAA → reg_mem4=0xAA. Separately, dstE=4 with dstM=0 → both registers written.
- **Stall and bubble:**
  - W_stall for 3 cycles while M_* changes → W_* held; reg_memN unchanged apart from the held value.
  - W_stall together with W_bubble → hold.
  - W_bubble alone → W_dstE=W_dstM=F and no write at the next edge.
- **Halt:**
  - M_stat=HLT with dstE=2 → no write to reg_mem2; halted=1 after edge 2.
  - Subsequent AOK inputs with dstE=1 → W_* frozen and reg_mem1 unchanged until rst.
- **RNONE:** dstE=F and dstM=F with nonzero values → no register changes.

Source files
------------

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 status, icode, register and bubble constants
package y86_pkg;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;

  localparam w_reg_t W_BUBBLE = '{
    stat:  STAT_AOK,
    icode: I_NOP,
    val_e: 64'd0,
    val_m: 64'd0,
    dst_e: RNONE,
    dst_m: RNONE
  };

endpackage

// File: rtl/regfile_15x64.sv
// rtl/regfile_15x64.sv - 15x64 register file, two write ports (port M wins), parallel reads
module regfile_15x64
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  output logic [63:0] reg_mem0,
  output logic [63:0] reg_mem1,
  output logic [63:0] reg_mem2,
  output logic [63:0] reg_mem3,
  output logic [63:0] reg_mem4,
  output logic [63:0] reg_mem5,
  output logic [63:0] reg_mem6,
  output logic [63:0] reg_mem7,
  output logic [63:0] reg_mem8,
  output logic [63:0] reg_mem9,
  output logic [63:0] reg_mem10,
  output logic [63:0] reg_mem11,
  output logic [63:0] reg_mem12,
  output logic [63:0] reg_mem13,
  output logic [63:0] reg_mem14
);

  logic [63:0] regs [15];

  // Index RNONE never matches a slot, so no explicit guard is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++)
        regs[i] <= (4'(i) == RRSP) ? RSP_INIT : 64'd0;
    end else if (wr_en) begin
      for (int i = 0; i < 15; i++) begin
        if (dst_m == 4'(i))
          regs[i] <= val_m;
        else if (dst_e == 4'(i))
          regs[i] <= val_e;
      end
    end
  end

  assign reg_mem0  = regs[0];
  assign reg_mem1  = regs[1];
  assign reg_mem2  = regs[2];
  assign reg_mem3  = regs[3];
  assign reg_mem4  = regs[4];
  assign reg_mem5  = regs[5];
  assign reg_mem6  = regs[6];
  assign reg_mem7  = regs[7];
  assign reg_mem8  = regs[8];
  assign reg_mem9  = regs[9];
  assign reg_mem10 = regs[10];
  assign reg_mem11 = regs[11];
  assign reg_mem12 = regs[12];
  assign reg_mem13 = regs[13];
  assign reg_mem14 = regs[14];

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - Y86-64 W pipeline register, halt tracking and register file commit
module writeback_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valM,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] reg_mem0,
  output logic [63:0] reg_mem1,
  output logic [63:0] reg_mem2,
  output logic [63:0] reg_mem3,
  output logic [63:0] reg_mem4,
  output logic [63:0] reg_mem5,
  output logic [63:0] reg_mem6,
  output logic [63:0] reg_mem7,
  output logic [63:0] reg_mem8,
  output logic [63:0] reg_mem9,
  output logic [63:0] reg_mem10,
  output logic [63:0] reg_mem11,
  output logic [63:0] reg_mem12,
  output logic [63:0] reg_mem13,
  output logic [63:0] reg_mem14,
  output logic        halted
);

  w_reg_t w_q;
  logic   wr_en;

  // Once halted the whole stage freezes; stall beats bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      w_q <= W_BUBBLE;
    else if (!halted && !W_stall)
      w_q <= W_bubble ? W_BUBBLE
                      : '{stat: M_stat, icode: M_icode, val_e: M_valE,
                          val_m: M_valM, dst_e: M_dstE, dst_m: M_dstM};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted <= 1'b0;
    else if (w_q.stat != STAT_AOK)
      halted <= 1'b1;
  end

  // A stalled instruction keeps rewriting the same value, which is harmless
  assign wr_en = (w_q.stat == STAT_AOK) && !halted;

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;

  regfile_15x64 #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .dst_e    (w_q.dst_e),
    .val_e    (w_q.val_e),
    .dst_m    (w_q.dst_m),
    .val_m    (w_q.val_m),
    .reg_mem0 (reg_mem0),
    .reg_mem1 (reg_mem1),
    .reg_mem2 (reg_mem2),
    .reg_mem3 (reg_mem3),
    .reg_mem4 (reg_mem4),
    .reg_mem5 (reg_mem5),
    .reg_mem6 (reg_mem6),
    .reg_mem7 (reg_mem7),
    .reg_mem8 (reg_mem8),
    .reg_mem9 (reg_mem9),
    .reg_mem10(reg_mem10),
    .reg_mem11(reg_mem11),
    .reg_mem12(reg_mem12),
    .reg_mem13(reg_mem13),
    .reg_mem14(reg_mem14)
  );

endmodule
